pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID and ID/EX pipeline latches of the 5-stage core (IF,ID,EX,MEM,WB).
//  Detects RAW hazards against in-flight destination regs, inserts bubbles into ID/EX and freezes PC/IF-ID.
//  Flushes younger instructions on a taken branch resolved in EX. Counts stall and flush cycles.
// PARAMETERS
//  FWD_EN     1   1: forwarding present, only load-use stalls; 0: any in-flight write to a source stalls
//  HAZ_DEPTH  3   scoreboard slots tracked after ID (EX, MEM, WB); legal 1..4
//  CNT_W      16  width of the saturating performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous reset, active high
//  id_rs1          in   3      decode-stage source reg 1
//  id_rs2          in   3      decode-stage source reg 2
//  id_use_rs1      in   1      ID instruction reads rs1
//  id_use_rs2      in   1      ID instruction reads rs2
//  id_rd           in   3      decode-stage destination reg
//  id_wr_rd        in   1      ID instruction writes rd
//  id_is_load      in   1      ID instruction is a data-memory load
//  ex_br_taken     in   1      branch in EX resolved taken (1-cycle pulse)
//  freeze          in   1      global hold (memory wait); holds whole pipeline
//  pc_en           out  1      PC register load enable
//  if_id_en        out  1      IF/ID latch enable
//  if_id_flush     out  1      IF/ID latch loads NOP
//  id_ex_bubble    out  1      ID/EX latch loads NOP (opcode 5'b00000, all fields 0)
//  hz_state        out  2      FSM state, debug
//  stall_cnt       out  CNT_W  hazard-stall cycles, saturating
//  flush_cnt       out  CNT_W  flush events, saturating
// BEHAVIOUR
//  - State, scoreboard, counters registered; control outputs combinational from state, scoreboard, inputs.
//  - Reg 0 is a real register; no hardwired-zero exemption.
//  - Scoreboard slot i = {valid, rd, is_load}; slot0 = EX, slot1 = MEM, ... WB writes RF at clock edge.
//  - hazard = (use_rs1 & match(rs1)) | (use_rs2 & match(rs2)); FWD_EN=1: match only slot0.valid & slot0.is_load;
//    FWD_EN=0: match any valid slot 0..HAZ_DEPTH-1.
//  - Priority per cycle: rst > freeze > ex_br_taken > hazard > normal.
//  - rst: state RUN, scoreboard invalid, counters 0; while high pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
//  - freeze: pc_en=0, if_id_en=0, flush/bubble=0, scoreboard, state, counters hold; ex_br_taken ignored.
//  - flush (ex_br_taken & state!=FLUSH): pc_en=1 (PC takes target), if_id_flush=1, id_ex_bubble=1; slot0<=invalid;
//    state->FLUSH for exactly 1 cycle; flush_cnt+1. In FLUSH, ex_br_taken ignored (EX holds a bubble).
//  - hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, slot0<=invalid, state->STALL, stall_cnt+1 per cycle;
//    stays STALL while hazard persists, returns RUN the first cycle hazard clears.
//  - normal: pc_en=1, if_id_en=1, flush=0, bubble=0; slot0<={id_wr_rd, id_rd, id_is_load}.
//  - Non-freeze cycles shift slot[i]<=slot[i-1]; slot HAZ_DEPTH-1 retires.
//  - Latency: decision same cycle as ID contents; FWD_EN=1 load-use costs 1 cycle; FWD_EN=0 up to HAZ_DEPTH.
//  - Counters saturate at all-ones, never wrap. FSM states: RUN=0, STALL=1, FLUSH=2; code 3 unreachable, decodes as RUN.
//  - rst mid-STALL/FLUSH: next cycle RUN, all in-flight entries dropped.
// STRUCTURE
//  - Shared package/header: state encodings, NOP opcode, REG_W=3, OPC_W=5 constants.
//  - One sub-module: hz_scoreboard (shift register of {valid,rd,is_load} + match compare); FSM and counters in top.
// TESTING
//  - FWD_EN=1: load rd=3 enters EX, ID rs1=3 use_rs1=1 -> 1 cycle pc_en=0, id_ex_bubble=1, stall_cnt=1, then RUN.
//  - FWD_EN=0: ALU wr rd=2, next ID rs2=2 -> 3 stall cycles, stall_cnt=3, issue on 4th cycle.
//  - ex_br_taken pulse -> same cycle if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_cnt=1; second pulse in FLUSH ignored.
//  - ex_br_taken and hazard same cycle -> flush wins, stall_cnt unchanged, state FLUSH.
//  - freeze 4 cycles during STALL -> all outputs/counters hold, pc_en=0; hazard resolves after freeze drops.
//  - rst during STALL -> outputs at reset values; after release, same rs1 no longer stalls (scoreboard cleared).

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings, scoreboard slot layout and NOP opcode.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 3;
  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] NOP_OPC = 5'b00000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_slot_t;

  // Code 3 is unreachable; treat it as RUN so a glitch self-heals.
  function automatic hz_state_e decode_state(
    input logic [1:0] s
  );
    case (s)
      2'd1:    return ST_STALL;
      2'd2:    return ST_FLUSH;
      default: return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// In-flight destination tracker: one slot per stage after ID.
// Flags a RAW hazard against the ID source registers.
module hz_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int HAZ_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  sb_slot_t         ins,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             hazard
);

  sb_slot_t [HAZ_DEPTH-1:0] sb_q;
  sb_slot_t [HAZ_DEPTH-1:0] sb_d;

  logic hit1;
  logic hit2;
  logic elig;

  always_comb begin
    sb_d = sb_q;
    if (!hold) begin
      sb_d[0] = ins;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
  end

  // With forwarding only a load still sitting in EX cannot be bypassed.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    elig = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      elig = sb_q[i].valid
           & ((FWD_EN == 0)
           | ((i == 0) & sb_q[i].is_load));
      hit1 = hit1 | (elig & (sb_q[i].rd == rs1));
      hit2 = hit2 | (elig & (sb_q[i].rd == rs2));
    end
    hazard = (use_rs1 & hit1)
           | (use_rs2 & hit2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and ID/EX latch sequencing: stall on RAW hazards,
// flush on taken branches, global freeze, perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_rd,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             freeze,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0]       state_q;
  hz_state_e        state_d;
  hz_state_e        st;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  sb_slot_t         ins;
  logic             hazard;

  hz_scoreboard #(
    .FWD_EN    (FWD_EN),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .hold    (freeze),
    .ins     (ins),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .hazard  (hazard)
  );

  always_comb begin
    st           = decode_state(state_q);
    state_d      = st;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ins          = '{id_wr_rd, id_rd, id_is_load};
    stall_d      = stall_q;
    flush_d      = flush_q;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ins          = '0;
      state_d      = ST_RUN;
      stall_d      = '0;
      flush_d      = '0;
    end else if (freeze) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      ins      = '0;
    end else if (ex_br_taken && st != ST_FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ins          = '0;
      state_d      = ST_FLUSH;
      if (!(&flush_q)) flush_d = flush_q + CNT_W'(1);
    end else if (hazard) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      ins          = '0;
      state_d      = ST_STALL;
      if (!(&stall_q)) stall_d = stall_q + CNT_W'(1);
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz_state  = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: forwarding instance driven from a vector table,
// no-forwarding instance (2-bit counters) via hand sequences.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       frz;
  } in_t;

  typedef struct {
    logic       pc;
    logic       en;
    logic       fl;
    logic       bb;
    logic [1:0] st;
    int         sc;
    int         fc;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  x1, x0;

  logic        pc1, en1, fl1, bb1;
  logic [1:0]  st1;
  logic [15:0] sc1, fc1;
  logic        pc0, en0, fl0, bb0;
  logic [1:0]  st0;
  logic [1:0]  sc0, fc0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FWD_EN(1), .HAZ_DEPTH(3), .CNT_W(16)
  ) d1 (
    .clk(clk), .rst(rst),
    .id_rs1(x1.rs1), .id_rs2(x1.rs2),
    .id_use_rs1(x1.u1), .id_use_rs2(x1.u2),
    .id_rd(x1.rd), .id_wr_rd(x1.wr),
    .id_is_load(x1.ld), .ex_br_taken(x1.br),
    .freeze(x1.frz),
    .pc_en(pc1), .if_id_en(en1),
    .if_id_flush(fl1), .id_ex_bubble(bb1),
    .hz_state(st1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  pipeline_hazard_ctrl #(
    .FWD_EN(0), .HAZ_DEPTH(3), .CNT_W(2)
  ) d0 (
    .clk(clk), .rst(rst),
    .id_rs1(x0.rs1), .id_rs2(x0.rs2),
    .id_use_rs1(x0.u1), .id_use_rs2(x0.u2),
    .id_rd(x0.rd), .id_wr_rd(x0.wr),
    .id_is_load(x0.ld), .ex_br_taken(x0.br),
    .freeze(x0.frz),
    .pc_en(pc0), .if_id_en(en0),
    .if_id_flush(fl0), .id_ex_bubble(bb0),
    .hz_state(st0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  function automatic in_t vi(
    input int rs1, input int rs2,
    input int u1, input int u2,
    input int rd, input int wr, input int ld,
    input int br, input int frz
  );
    in_t r;
    r.rs1 = 3'(rs1);
    r.rs2 = 3'(rs2);
    r.u1  = 1'(u1);
    r.u2  = 1'(u2);
    r.rd  = 3'(rd);
    r.wr  = 1'(wr);
    r.ld  = 1'(ld);
    r.br  = 1'(br);
    r.frz = 1'(frz);
    return r;
  endfunction

  function automatic exp_t ve(
    input int pc, input int en,
    input int fl, input int bb,
    input int st, input int sc, input int fc
  );
    exp_t r;
    r.pc = 1'(pc);
    r.en = 1'(en);
    r.fl = 1'(fl);
    r.bb = 1'(bb);
    r.st = 2'(st);
    r.sc = sc;
    r.fc = fc;
    return r;
  endfunction

  task automatic cmp(input string nm, input int act,
                     input int req);
    total++;
    if (act != req)
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    else
      passed++;
  endtask

  task automatic chk1(input string t, input exp_t e);
    cmp({t, " pc_en"}, int'(pc1), int'(e.pc));
    cmp({t, " if_id_en"}, int'(en1), int'(e.en));
    cmp({t, " if_id_flush"}, int'(fl1), int'(e.fl));
    cmp({t, " id_ex_bubble"}, int'(bb1), int'(e.bb));
    cmp({t, " hz_state"}, int'(st1), int'(e.st));
    cmp({t, " stall_cnt"}, int'(sc1), e.sc);
    cmp({t, " flush_cnt"}, int'(fc1), e.fc);
  endtask

  task automatic chk0(input string t, input exp_t e);
    cmp({t, " pc_en"}, int'(pc0), int'(e.pc));
    cmp({t, " if_id_en"}, int'(en0), int'(e.en));
    cmp({t, " if_id_flush"}, int'(fl0), int'(e.fl));
    cmp({t, " id_ex_bubble"}, int'(bb0), int'(e.bb));
    cmp({t, " hz_state"}, int'(st0), int'(e.st));
    cmp({t, " stall_cnt"}, int'(sc0), e.sc);
    cmp({t, " flush_cnt"}, int'(fc0), e.fc);
  endtask

  task automatic step1(input string t, input in_t x,
                       input exp_t e);
    x1 = x;
    x0 = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1(t, e);
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input string t, input in_t x,
                       input exp_t e);
    x0 = x;
    x1 = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk0(t, e);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[17];
  in_t  idle, idb, u7, u7f, u3, u3f, u3fb;
  in_t  u2, u1;

  initial begin
    idle = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idb  = vi(0, 0, 0, 0, 0, 0, 0, 1, 0);

    tbl[0]  = '{idle, ve(1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{vi(0, 0, 0, 0, 3, 1, 1, 0, 0),
                ve(1, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{vi(3, 0, 1, 0, 0, 0, 0, 0, 0),
                ve(0, 0, 0, 1, 0, 0, 0)};
    tbl[3]  = '{vi(3, 0, 1, 0, 0, 0, 0, 0, 0),
                ve(1, 1, 0, 0, 1, 1, 0)};
    tbl[4]  = '{vi(0, 0, 0, 0, 5, 1, 0, 0, 0),
                ve(1, 1, 0, 0, 0, 1, 0)};
    tbl[5]  = '{vi(0, 5, 0, 1, 0, 0, 0, 0, 0),
                ve(1, 1, 0, 0, 0, 1, 0)};
    tbl[6]  = '{vi(0, 0, 0, 0, 0, 1, 1, 0, 0),
                ve(1, 1, 0, 0, 0, 1, 0)};
    tbl[7]  = '{idle, ve(1, 1, 0, 0, 0, 1, 0)};
    tbl[8]  = '{vi(0, 0, 0, 0, 0, 1, 1, 0, 0),
                ve(1, 1, 0, 0, 0, 1, 0)};
    tbl[9]  = '{vi(0, 0, 0, 1, 0, 0, 0, 0, 0),
                ve(0, 0, 0, 1, 0, 1, 0)};
    tbl[10] = '{idle, ve(1, 1, 0, 0, 1, 2, 0)};
    tbl[11] = '{idb, ve(1, 1, 1, 1, 0, 2, 0)};
    tbl[12] = '{idb, ve(1, 1, 0, 0, 2, 2, 1)};
    tbl[13] = '{vi(0, 0, 0, 0, 4, 1, 1, 0, 0),
                ve(1, 1, 0, 0, 0, 2, 1)};
    tbl[14] = '{vi(4, 0, 1, 0, 0, 0, 0, 1, 0),
                ve(1, 1, 1, 1, 0, 2, 1)};
    tbl[15] = '{idle, ve(1, 1, 0, 0, 2, 2, 2)};
    tbl[16] = '{vi(4, 0, 1, 0, 0, 0, 0, 0, 0),
                ve(1, 1, 0, 0, 0, 2, 2)};

    rst = 1'b1;
    x1  = idle;
    x0  = idle;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst", ve(0, 0, 1, 1, 0, 0, 0));
    chk0("rst0", ve(0, 0, 1, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      step1($sformatf("tbl%0d", k), tbl[k].i, tbl[k].e);
    end

    // freeze holds a load in EX, then freeze across STALL
    u7  = vi(7, 0, 1, 0, 0, 0, 0, 0, 0);
    u7f = vi(7, 0, 1, 0, 0, 0, 0, 0, 1);
    step1("fz_ld", vi(0, 0, 0, 0, 7, 1, 1, 0, 0),
          ve(1, 1, 0, 0, 0, 2, 2));
    step1("fz_a0", u7f, ve(0, 0, 0, 0, 0, 2, 2));
    step1("fz_a1", u7f, ve(0, 0, 0, 0, 0, 2, 2));
    step1("fz_haz", u7, ve(0, 0, 0, 1, 0, 2, 2));
    step1("fz_b0", u7f, ve(0, 0, 0, 0, 1, 3, 2));
    u3fb = vi(7, 0, 1, 0, 0, 0, 0, 1, 1);
    step1("fz_b1", u3fb, ve(0, 0, 0, 0, 1, 3, 2));
    step1("fz_b2", u7f, ve(0, 0, 0, 0, 1, 3, 2));
    step1("fz_b3", u7f, ve(0, 0, 0, 0, 1, 3, 2));
    step1("fz_go", u7, ve(1, 1, 0, 0, 1, 3, 2));
    step1("fz_run", idle, ve(1, 1, 0, 0, 0, 3, 2));

    // no forwarding: ALU result stalls a dependent for 3 cycles
    u2 = vi(0, 2, 0, 1, 0, 0, 0, 0, 0);
    step0("nf_alu", vi(0, 0, 0, 0, 2, 1, 0, 0, 0),
          ve(1, 1, 0, 0, 0, 0, 0));
    step0("nf_s1", u2, ve(0, 0, 0, 1, 0, 0, 0));
    step0("nf_s2", u2, ve(0, 0, 0, 1, 1, 1, 0));
    step0("nf_s3", u2, ve(0, 0, 0, 1, 1, 2, 0));
    step0("nf_go", u2, ve(1, 1, 0, 0, 1, 3, 0));

    // 2-bit stall counter saturates at 3
    u1 = vi(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step0("sat_alu", vi(0, 0, 0, 0, 1, 1, 0, 0, 0),
          ve(1, 1, 0, 0, 0, 3, 0));
    step0("sat_s1", u1, ve(0, 0, 0, 1, 0, 3, 0));
    step0("sat_s2", u1, ve(0, 0, 0, 1, 1, 3, 0));
    step0("sat_s3", u1, ve(0, 0, 0, 1, 1, 3, 0));
    step0("sat_go", u1, ve(1, 1, 0, 0, 1, 3, 0));

    // 2-bit flush counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      step0($sformatf("fsat_br%0d", k), idb,
            ve(1, 1, 1, 1, 0, 3, (k > 3) ? 3 : k));
      step0($sformatf("fsat_fl%0d", k), idle,
            ve(1, 1, 0, 0, 2, 3, (k + 1 > 3) ? 3 : k + 1));
    end

    // reset in STALL clears scoreboard and counters
    step0("r_alu", vi(0, 0, 0, 0, 1, 1, 0, 0, 0),
          ve(1, 1, 0, 0, 0, 3, 3));
    step0("r_s1", u1, ve(0, 0, 0, 1, 0, 3, 3));
    x0  = u1;
    rst = 1'b1;
    @(negedge clk);
    cmp("r_mid pc_en", int'(pc0), 0);
    cmp("r_mid if_id_en", int'(en0), 0);
    cmp("r_mid if_id_flush", int'(fl0), 1);
    cmp("r_mid id_ex_bubble", int'(bb0), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step0("r_post", u1, ve(1, 1, 0, 0, 0, 0, 0));
    cmp("r_post d1 stall_cnt", int'(sc1), 0);
    cmp("r_post d1 flush_cnt", int'(fc1), 0);

    u3 = idle;
    u3f = idle;
    if (u3 != u3f) $display("unused");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
